// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : RV32I multicycle sequencer with memory handshake, timeout trap
//               and instruction-retire pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode_i,
    input  logic [2:0]         func3_i,
    input  logic [6:0]         func7_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               iord_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pcsrc_o,
    output logic               alusrc_o,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               regwrite_o,
    output logic [1:0]         memtoreg_o,
    output logic               retire_o,
    output logic               trap_o,
    output logic [3:0]         state_o
);

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;

    localparam logic [ALUOP_W-1:0] c_ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALU_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_ALU_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] c_ALU_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] c_ALU_SLL  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] c_ALU_SRL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] c_ALU_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] c_ALU_SLT  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] c_ALU_SLTU = ALUOP_W'(9);

    localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_ALU_WB  = 4'd4,
        S_ADDR    = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_LOAD_WB = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_TRAP    = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_timeout;
    logic             w_wait_state;
    logic             w_unused_func7;

    // Only func7[5] distinguishes SUB/SRA; the other bits are don't-care here.
    assign w_unused_func7 = ^{func7_i[6], func7_i[4:0]};

    assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                          (state_q == S_MEM_WR);
    assign w_timeout    = (MEM_TIMEOUT != 0) && (cnt_q == c_CNT_LIMIT) && !mem_ready_i;
    assign state_o      = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter only advances while parked in a memory state; any move clears it.
    always_comb begin
        cnt_d = '0;
        if (w_wait_state && (state_d == state_q) && !mem_ready_i) begin
            cnt_d = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        iord_o          = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pcsrc_o         = 2'b00;
        alusrc_o        = 1'b0;
        aluop_o         = c_ALU_ADD;
        regwrite_o      = 1'b0;
        memtoreg_o      = 2'b00;
        retire_o        = 1'b0;
        trap_o          = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    c_OP_R, c_OP_I:      state_d = S_EXEC;
                    c_OP_LW, c_OP_SW:    state_d = S_ADDR;
                    c_OP_BEQ:            state_d = S_BRANCH;
                    c_OP_JAL, c_OP_JALR: state_d = S_JUMP;
                    default:             state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                alusrc_o = (opcode_i == c_OP_I);
                case (func3_i)
                    3'b000:  aluop_o = ((opcode_i == c_OP_R) && func7_i[5]) ? c_ALU_SUB : c_ALU_ADD;
                    3'b001:  aluop_o = c_ALU_SLL;
                    3'b010:  aluop_o = c_ALU_SLT;
                    3'b011:  aluop_o = c_ALU_SLTU;
                    3'b100:  aluop_o = c_ALU_XOR;
                    3'b101:  aluop_o = func7_i[5] ? c_ALU_SRA : c_ALU_SRL;
                    3'b110:  aluop_o = c_ALU_OR;
                    default: aluop_o = c_ALU_AND;
                endcase
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                regwrite_o = 1'b1;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDR: begin
                alusrc_o = 1'b1;
                state_d  = (opcode_i == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_LOAD_WB;
                end else if (w_timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (w_timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_LOAD_WB: begin
                regwrite_o = 1'b1;
                memtoreg_o = 2'b01;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                aluop_o         = c_ALU_SUB;
                pc_write_cond_o = 1'b1;
                pcsrc_o         = 2'b01;
                retire_o        = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                regwrite_o = 1'b1;
                memtoreg_o = 2'b10;
                pc_write_o = 1'b1;
                alusrc_o   = 1'b1;
                retire_o   = 1'b1;
                pcsrc_o    = (opcode_i == c_OP_JALR) ? 2'b11 : 2'b10;
                state_d    = S_FETCH;
            end
            S_TRAP:  trap_o  = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Scoreboard bench; instruction-level model predicts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pcsrc, memtoreg;
    logic       alusrc, regwrite, retire, trap;
    logic [3:0] aluop, state;

    multicycle_control_unit #(
        .ALUOP_W     (4),
        .MEM_TIMEOUT (TO),
        .CNT_W       (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode_i        (opcode),
        .func3_i         (func3),
        .func7_i         (func7),
        .mem_ready_i     (mem_ready),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .iord_o          (iord),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .pcsrc_o         (pcsrc),
        .alusrc_o        (alusrc),
        .aluop_o         (aluop),
        .regwrite_o      (regwrite),
        .memtoreg_o      (memtoreg),
        .retire_o        (retire),
        .trap_o          (trap),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, iord, irw, pcw, pcwc;
        logic [1:0] pcsrc;
        logic       alusrc;
        logic [3:0] aluop;
        logic       regw;
        logic [1:0] m2r;
        logic       ret, trap;
    } out_t;

    out_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    out_t  m_e, m_g;
    string m_t;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_t = tag_q.pop_front();
            m_g.st = state;      m_g.req = mem_req;   m_g.we = mem_we;
            m_g.iord = iord;     m_g.irw = ir_write;  m_g.pcw = pc_write;
            m_g.pcwc = pc_write_cond;                 m_g.pcsrc = pcsrc;
            m_g.alusrc = alusrc; m_g.aluop = aluop;   m_g.regw = regwrite;
            m_g.m2r = memtoreg;  m_g.ret = retire;    m_g.trap = trap;
            n_tests++;
            if (m_g !== m_e) begin
                n_fail++;
                $display("FAIL %s @%0t: got st=%0d fields=%b, expected st=%0d fields=%b",
                         m_t, $time, m_g.st, m_g[17:0], m_e.st, m_e[17:0]);
            end
        end
    end

    function automatic out_t mk(input logic [3:0] st);
        out_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Instruction class: 0 R, 1 I, 2 LW, 3 SW, 4 BEQ, 5 JAL, 6 JALR, -1 illegal
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            7'b1100111: return 6;
            default:    return -1;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input int c, input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return (c == 0 && f7[5]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd8;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7[5] ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic cyc(input out_t e, input string t, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_from(input out_t cur, input string t);
        rst_n = 1'b0;
        cyc(cur, t, rb());
        rst_n = 1'b1;
        cyc(mk(4'd0), "reset", rb());
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fw, input int mw, input int trap_cycles);
        out_t e;
        int   c;
        opcode = op; func3 = f3; func7 = f7;
        c = cls_of(op);
        for (int i = 0; i < fw; i++) begin
            e = mk(4'd1); e.req = 1'b1;
            cyc(e, "fetch_wait", 1'b0);
        end
        e = mk(4'd1); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(e, "fetch_done", 1'b1);
        cyc(mk(4'd2), "decode", rb());
        case (c)
            0, 1: begin
                e = mk(4'd3); e.alusrc = (c == 1); e.aluop = exp_alu(c, f3, f7);
                cyc(e, "exec", rb());
                e = mk(4'd4); e.regw = 1'b1; e.ret = 1'b1;
                cyc(e, "alu_wb", rb());
            end
            2, 3: begin
                e = mk(4'd5); e.alusrc = 1'b1;
                cyc(e, "addr", rb());
                e = mk((c == 2) ? 4'd6 : 4'd7); e.req = 1'b1; e.iord = 1'b1; e.we = (c == 3);
                for (int i = 0; i < mw; i++) cyc(e, "mem_wait", 1'b0);
                e.ret = (c == 3);
                cyc(e, "mem_done", 1'b1);
                if (c == 2) begin
                    e = mk(4'd8); e.regw = 1'b1; e.m2r = 2'b01; e.ret = 1'b1;
                    cyc(e, "load_wb", rb());
                end
            end
            4: begin
                e = mk(4'd9); e.aluop = 4'd1; e.pcwc = 1'b1; e.pcsrc = 2'b01; e.ret = 1'b1;
                cyc(e, "branch", rb());
            end
            5, 6: begin
                e = mk(4'd10); e.regw = 1'b1; e.m2r = 2'b10; e.pcw = 1'b1; e.alusrc = 1'b1;
                e.ret = 1'b1; e.pcsrc = (c == 5) ? 2'b10 : 2'b11;
                cyc(e, "jump", rb());
            end
            default: begin
                e = mk(4'd15); e.trap = 1'b1;
                for (int i = 0; i < trap_cycles; i++) cyc(e, "trap_hold", rb());
                reset_from(e, "trap_at_rst");
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        out_t       e;
        logic [6:0] op;
        logic [6:0] ops [7];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(mk(4'd0), "reset", 1'b1);

        run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, 0);
        run_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0, 0);
        run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3, 0);
        run_instr(7'b1100011, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr(7'b1100111, 3'b000, 7'b0000000, 0, 0, 0);
        run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0, 20);

        // Fetch never completes: 16 waiting cycles, then trap.
        opcode = 7'b0110011;
        for (int i = 0; i < TO + 1; i++) begin
            e = mk(4'd1); e.req = 1'b1;
            cyc(e, "to_fetch_wait", 1'b0);
        end
        e = mk(4'd15); e.trap = 1'b1;
        repeat (3) cyc(e, "to_trap", rb());
        reset_from(e, "to_trap_at_rst");

        // Ready arrives on the last allowed cycle: no trap.
        run_instr(7'b0110011, 3'b111, 7'b0000000, TO, 0, 0);

        // Reset in the middle of a load wait.
        opcode = 7'b0000011;
        e = mk(4'd1); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(e, "mr_fetch", 1'b1);
        cyc(mk(4'd2), "mr_decode", 1'b0);
        e = mk(4'd5); e.alusrc = 1'b1;
        cyc(e, "mr_addr", 1'b0);
        e = mk(4'd6); e.req = 1'b1; e.iord = 1'b1;
        cyc(e, "mr_wait", 1'b0);
        cyc(e, "mr_wait", 1'b0);
        rst_n = 1'b0;
        cyc(e, "mr_wait_at_rst", 1'b0);
        rst_n = 1'b1;
        cyc(mk(4'd0), "mr_reset", 1'b0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 7'($urandom); while (cls_of(op) >= 0);
            end else begin
                op = ops[$urandom_range(0, 6)];
            end
            run_instr(op, 3'($urandom), 7'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 4), $urandom_range(1, 3));
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
